// File: rtl/dcmac_segmenter.sv
// dcmac_segmenter: splits one 512-bit AXI stream into four lockstep 128-bit
// segment streams for the 4-segment TX packetizer, with {ena,mty} per segment
// in tuser. Packets longer than MAX_PACKET_SIZE bytes are cut: the last
// allowed beat gets a forced tlast and the rest of the packet is discarded.
// This keeps the downstream packet FIFOs from overfilling and deadlocking.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   axis_in_*             512-bit input stream (tdata/tkeep/tlast/tvalid/tready)
//   axisN_out_*           segment N (N=0..3): tdata[127:0], tuser[4:0]={ena,mty},
//                         tlast, tvalid (shared), tready (all four must be high)
//   truncated             1-cycle pulse when an oversize packet is cut
//   pkt_count             packets emitted, wraps
//   trunc_count           packets truncated, saturates
//
// Build option DCMAC_SEGMENTER_STATS_EN: when defined, truncated/pkt_count/
// trunc_count are live; otherwise they are tied to 0 and the counters vanish.

// Per-segment byte accounting: ena = any byte valid, mty = empty bytes.
module dcmac_seg_lane (
  input  logic [15:0] keep,
  output logic [4:0]  user
);
  logic [4:0] n;
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(keep[i]);
  end
  // n==16 gives mty 0 via the 4-bit truncation of 16-n
  assign user = (|keep) ? {1'b1, 4'(5'd16 - n)} : 5'd0;
endmodule

module dcmac_segmenter #(
  parameter int MAX_PACKET_SIZE = 16384
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] axis_in_tdata,
  input  logic [63:0]  axis_in_tkeep,
  input  logic         axis_in_tlast,
  input  logic         axis_in_tvalid,
  output logic         axis_in_tready,
  output logic [127:0] axis0_out_tdata,
  output logic [4:0]   axis0_out_tuser,
  output logic         axis0_out_tlast,
  output logic         axis0_out_tvalid,
  input  logic         axis0_out_tready,
  output logic [127:0] axis1_out_tdata,
  output logic [4:0]   axis1_out_tuser,
  output logic         axis1_out_tlast,
  output logic         axis1_out_tvalid,
  input  logic         axis1_out_tready,
  output logic [127:0] axis2_out_tdata,
  output logic [4:0]   axis2_out_tuser,
  output logic         axis2_out_tlast,
  output logic         axis2_out_tvalid,
  input  logic         axis2_out_tready,
  output logic [127:0] axis3_out_tdata,
  output logic [4:0]   axis3_out_tuser,
  output logic         axis3_out_tlast,
  output logic         axis3_out_tvalid,
  input  logic         axis3_out_tready,
  output logic         truncated,
  output logic [31:0]  pkt_count,
  output logic [31:0]  trunc_count
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 128;
  localparam int MAX_BEATS = MAX_PACKET_SIZE / 64;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     beat_cnt_q, beat_cnt_d;
  logic                                 out_valid, out_last, out_ready;
  logic [NUM_LANES-1:0][VEC_W-1:0]      out_data;
  logic [NUM_LANES-1:0][4:0]            out_user, lane_user;
  logic                                 in_fire, emit, force_last;

  assign out_ready = axis0_out_tready & axis1_out_tready &
                     axis2_out_tready & axis3_out_tready;
  // DROP never touches the output register, so it can sink beats even
  // while the forced-last beat is still waiting downstream.
  assign axis_in_tready = ~out_valid | out_ready | (state_q == DROP);
  assign in_fire = axis_in_tvalid & axis_in_tready;

  for (genvar s = 0; s < NUM_LANES; s++) begin : g_lane
    dcmac_seg_lane u_lane (
      .keep (axis_in_tkeep[16*s +: 16]),
      .user (lane_user[s])
    );
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    emit       = 1'b0;
    force_last = 1'b0;
    if (in_fire) begin
      if (state_q == DROP) begin
        if (axis_in_tlast) state_d = IDLE;
      end else if (axis_in_tlast || (|axis_in_tkeep)) begin
        // empty non-last beats fall through: dropped, not counted
        emit       = 1'b1;
        force_last = (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) & ~axis_in_tlast;
        if (axis_in_tlast || force_last) begin
          beat_cnt_d = '0;
          state_d    = force_last ? DROP : IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          state_d    = BODY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_user   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= axis_in_tlast | force_last;
        out_data  <= axis_in_tdata;
        out_user  <= lane_user;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign axis0_out_tdata  = out_data[0];
  assign axis1_out_tdata  = out_data[1];
  assign axis2_out_tdata  = out_data[2];
  assign axis3_out_tdata  = out_data[3];
  assign axis0_out_tuser  = out_user[0];
  assign axis1_out_tuser  = out_user[1];
  assign axis2_out_tuser  = out_user[2];
  assign axis3_out_tuser  = out_user[3];
  assign axis0_out_tlast  = out_last;
  assign axis1_out_tlast  = out_last;
  assign axis2_out_tlast  = out_last;
  assign axis3_out_tlast  = out_last;
  assign axis0_out_tvalid = out_valid;
  assign axis1_out_tvalid = out_valid;
  assign axis2_out_tvalid = out_valid;
  assign axis3_out_tvalid = out_valid;

`ifdef DCMAC_SEGMENTER_STATS_EN
  logic        trunc_q;
  logic [31:0] pkt_q, trunc_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trunc_q     <= 1'b0;
      pkt_q       <= '0;
      trunc_cnt_q <= '0;
    end else begin
      trunc_q <= emit & force_last;
      if (emit && (axis_in_tlast || force_last)) pkt_q <= pkt_q + 32'd1;
      if (emit && force_last && (trunc_cnt_q != '1)) trunc_cnt_q <= trunc_cnt_q + 32'd1;
    end
  end
  assign truncated   = trunc_q;
  assign pkt_count   = pkt_q;
  assign trunc_count = trunc_cnt_q;
`else
  assign truncated   = 1'b0;
  assign pkt_count   = '0;
  assign trunc_count = '0;
`endif

endmodule

// File: tb/tb_dcmac_segmenter.sv
// Directed bench for dcmac_segmenter with MAX_PACKET_SIZE=256 (4 beats).
// Inputs are driven at the falling edge; outputs are sampled 1 ns later.
// A small packet model builds the expected beat queue; every beat consumed
// at the outputs is compared against it.
module tb_dcmac_segmenter;
  localparam int MPS  = 256;
  localparam int MAXB = MPS / 64;
`ifdef DCMAC_SEGMENTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] in_data;
  logic [63:0]  in_keep;
  logic         in_last, in_valid;
  wire          in_ready;
  wire  [127:0] o_data [4];
  wire  [4:0]   o_user [4];
  wire  [3:0]   o_last, o_valid;
  logic [3:0]   rdy;
  wire          truncated;
  wire  [31:0]  pkt_count, trunc_count;

  always #5 clk = ~clk;

  dcmac_segmenter #(.MAX_PACKET_SIZE(MPS)) dut (
    .clk(clk), .reset(reset),
    .axis_in_tdata(in_data), .axis_in_tkeep(in_keep), .axis_in_tlast(in_last),
    .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
    .axis0_out_tdata(o_data[0]), .axis0_out_tuser(o_user[0]), .axis0_out_tlast(o_last[0]),
    .axis0_out_tvalid(o_valid[0]), .axis0_out_tready(rdy[0]),
    .axis1_out_tdata(o_data[1]), .axis1_out_tuser(o_user[1]), .axis1_out_tlast(o_last[1]),
    .axis1_out_tvalid(o_valid[1]), .axis1_out_tready(rdy[1]),
    .axis2_out_tdata(o_data[2]), .axis2_out_tuser(o_user[2]), .axis2_out_tlast(o_last[2]),
    .axis2_out_tvalid(o_valid[2]), .axis2_out_tready(rdy[2]),
    .axis3_out_tdata(o_data[3]), .axis3_out_tuser(o_user[3]), .axis3_out_tlast(o_last[3]),
    .axis3_out_tvalid(o_valid[3]), .axis3_out_tready(rdy[3]),
    .truncated(truncated), .pkt_count(pkt_count), .trunc_count(trunc_count)
  );

  wire [511:0] cur_data = {o_data[3], o_data[2], o_data[1], o_data[0]};
  wire [19:0]  cur_user = {o_user[3], o_user[2], o_user[1], o_user[0]};

  typedef struct { logic [511:0] d; logic [19:0] u; logic l; } beat_t;
  beat_t q[$];

  int errors = 0, checks = 0;
  int m_cnt = 0, exp_pkts = 0, exp_trunc = 0, trunc_seen = 0, hold2 = 0;
  bit m_drop = 0, rand_rdy = 0, prev_stall = 0;
  logic [511:0] prev_data;
  logic [19:0]  prev_user;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] exp_user(input logic [63:0] k);
    logic [19:0] u;
    int n;
    for (int s = 0; s < 4; s++) begin
      n = $countones(k[16*s +: 16]);
      u[5*s +: 5] = (n == 0) ? 5'd0 : {1'b1, 4'(16 - n)};
    end
    return u;
  endfunction

  task automatic model(input logic [511:0] d, input logic [63:0] k, input bit l);
    bit f;
    if (m_drop) begin
      if (l) m_drop = 0;
    end else if (k != 0 || l) begin
      f = (m_cnt == MAXB - 1) && !l;
      q.push_back('{d, exp_user(k), l || f});
      if (l || f) begin m_cnt = 0; exp_pkts++; end else m_cnt++;
      if (f) begin m_drop = 1; exp_trunc++; end
    end
  endtask

  // called just after a falling edge with inputs already driven
  task automatic tick(output bit hs);
    bit hold_now;
    beat_t b;
    for (int s = 0; s < 4; s++) rdy[s] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    hold_now = (hold2 > 0);
    if (hold_now) begin rdy[2] = 1'b0; hold2--; end
    #1;
    chk("vld_eq", o_valid, {4{o_valid[0]}});
    chk("last_eq", o_last, {4{o_last[0]}});
    if (prev_stall) begin
      chk("hold_data", cur_data, prev_data);
      chk("hold_user", cur_user, prev_user);
    end
    if (hold_now && o_valid[0]) chk("stall_ready", in_ready, 0);
    trunc_seen += int'(truncated);
    if (o_valid[0] && (&rdy)) begin
      if (q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        b = q.pop_front();
        chk("beat_data", cur_data, b.d);
        chk("beat_user", cur_user, b.u);
        chk("beat_last", o_last[0], b.l);
      end
    end
    prev_stall = o_valid[0] && !(&rdy);
    prev_data  = cur_data;
    prev_user  = cur_user;
    hs = in_valid && in_ready;
    @(posedge clk);
  endtask

  task automatic send(input logic [511:0] d, input logic [63:0] k, input bit l);
    bit hs = 0;
    int n = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
      tick(hs);
      n++;
    end
    if (!hs) chk("send_timeout", 0, 1);
    else model(d, k, l);
  endtask

  task automatic idle(input int n);
    bit hs;
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      tick(hs);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin idle(1); n++; end
    chk("drain_left", q.size(), 0);
    idle(2);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkts"}, pkt_count, STATS ? exp_pkts : 0);
    chk({tag, "_trunc_cnt"}, trunc_count, STATS ? exp_trunc : 0);
    chk({tag, "_trunc_pulses"}, trunc_seen, STATS ? exp_trunc : 0);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_pkt(input int nbytes);
    int rem = nbytes;
    logic [63:0] k;
    while (rem > 0) begin
      k = '1;
      if (rem < 64) k = (64'd1 << rem) - 64'd1;
      send(rnd512(), k, rem <= 64);
      rem -= 64;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] d;
    int sizes[12] = '{1, 15, 16, 17, 63, 64, 65, 128, 129, 192, 255, 256};
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; rdy = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", cur_data, 0);
    chk("rst_user", cur_user, 0);
    chk("rst_truncated", truncated, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_trunc_count", trunc_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); reset = 1'b0;

    // 1: single 64B beat
    d = rnd512();
    send(d, '1, 1'b1);
    #1;
    chk("t1_valid", o_valid, 4'hF);
    chk("t1_last", o_last, 4'hF);
    chk("t1_user", cur_user, {4{5'h10}});
    chk("t1_data", cur_data, d);
    chk("t1_pkts", pkt_count, STATS ? 1 : 0);
    drain();

    // 2: two-beat packet, short tail in segment 0
    send(rnd512(), '1, 1'b0);
    send(rnd512(), 64'h0000_0000_0000_000F, 1'b1);
    #1;
    chk("t2_user", cur_user, {15'd0, 5'h1C});
    chk("t2_last", o_last, 4'hF);
    drain();

    // non-contiguous keep: mty follows popcount only
    send(rnd512(), {16'h00F0, 16'h0000, 16'h8001, 16'hFFFF}, 1'b1);
    #1;
    chk("nc_user", cur_user, {5'h1C, 5'h00, 5'h1E, 5'h10});
    drain();

    // empty non-last beat dropped; empty last beat still closes the packet
    send(rnd512(), '1, 1'b0);
    send(rnd512(), '0, 1'b0);
    send(rnd512(), '0, 1'b1);
    #1;
    chk("zl_user", cur_user, 0);
    chk("zl_last", o_last, 4'hF);
    chk("zl_valid", o_valid, 4'hF);
    drain();

    // exactly MAXB beats (plus an empty filler beat) is not truncated
    for (int b = 0; b < MAXB; b++) begin
      send(rnd512(), '1, b == MAXB - 1);
      if (b == 1) send(rnd512(), '0, 1'b0);
    end
    drain();
    check_stats("exact");

    // 3: 6-beat packet is cut after beat 4
    for (int b = 0; b < 6; b++) begin
      send(rnd512(), '1, b == 5);
      if (b == 3) begin
        #1;
        chk("t3_forced_last", o_last, 4'hF);
      end
    end
    drain();
    check_stats("t3");

    // 4: segment 2 back-pressured mid-packet
    send(rnd512(), '1, 1'b0);
    hold2 = 5;
    send(rnd512(), '1, 1'b0);
    send(rnd512(), '1, 1'b1);
    drain();
    check_stats("t4");

    // 5: reset in the middle of a packet
    send(rnd512(), '1, 1'b0);
    send(rnd512(), '1, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("t5_valid", o_valid, 0);
    chk("t5_data", cur_data, 0);
    chk("t5_pkts", pkt_count, 0);
    q.delete(); m_cnt = 0; m_drop = 0; exp_pkts = 0; exp_trunc = 0;
    trunc_seen = 0; prev_stall = 0;
    @(negedge clk); reset = 1'b0;
    for (int b = 0; b < MAXB; b++) send(rnd512(), '1, b == MAXB - 1);
    drain();
    check_stats("t5");

    // 6: back-to-back packets of assorted sizes, random per-segment ready
    rand_rdy = 1;
    foreach (sizes[i]) send_pkt(sizes[i]);
    for (int i = 0; i < 10; i++) send_pkt($urandom_range(1, MPS));
    drain();
    rand_rdy = 0;
    idle(1);
    check_stats("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
